// File: rtl/ball_game_ctrl.sv
// Per-frame scheduler for the two-ball game: moves both balls during vertical blank,
// then runs a squared-distance collision test on one shared multiplier.
module ball_game_ctrl #(
    parameter int unsigned H_ACT     = 640,
    parameter int unsigned V_ACT     = 480,
    parameter int unsigned RADIUS    = 30,
    parameter int unsigned U_RADIUS  = 30,
    parameter int unsigned STEP      = 1,
    parameter int unsigned FRAME_DIV = 1,
    parameter int unsigned PX_INIT   = 200,
    parameter int unsigned PY_INIT   = 200,
    parameter int unsigned UX_INIT   = 400,
    parameter int unsigned UY_INIT   = 400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        restart,
    output logic [12:0] ball_x,
    output logic [12:0] ball_y,
    output logic [12:0] user_x,
    output logic [12:0] user_y,
    output logic        game_over,
    output logic        busy
);

    localparam int unsigned CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);

    localparam logic [12:0] B_LO  = 13'(RADIUS);
    localparam logic [12:0] BX_HI = 13'(H_ACT - RADIUS);
    localparam logic [12:0] BY_HI = 13'(V_ACT - RADIUS);
    localparam logic [12:0] U_LO  = 13'(U_RADIUS);
    localparam logic [12:0] UX_HI = 13'(H_ACT - U_RADIUS);
    localparam logic [12:0] UY_HI = 13'(V_ACT - U_RADIUS);
    localparam logic [12:0] STP   = 13'(STEP);
    localparam logic [12:0] PX0   = 13'(PX_INIT);
    localparam logic [12:0] PY0   = 13'(PY_INIT);
    localparam logic [12:0] UX0   = 13'(UX_INIT);
    localparam logic [12:0] UY0   = 13'(UY_INIT);
    localparam logic [26:0] HIT_LIM = 27'((RADIUS + U_RADIUS) * (RADIUS + U_RADIUS));

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StMoveBall = 3'd1;
    localparam logic [2:0] StMoveUser = 3'd2;
    localparam logic [2:0] StDist     = 3'd3;
    localparam logic [2:0] StSqx      = 3'd4;
    localparam logic [2:0] StSqy      = 3'd5;
    localparam logic [2:0] StCmp      = 3'd6;
    localparam logic [2:0] StOver     = 3'd7;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [12:0]   bx_q, bx_d, by_q, by_d, ux_q, ux_d, uy_q, uy_d;
    logic          dirx_q, dirx_d, diry_q, diry_d;
    logic [12:0]   dx_q, dx_d, dy_q, dy_d;
    logic [26:0]   acc_q, acc_d;
    logic          over_q, over_d;
    logic          dirx_n, diry_n;
    logic [12:0]   sq_op;
    logic [25:0]   prod;

    // Step one unit up or down, saturating at [lo, hi]; 14-bit math avoids wrap.
    function automatic logic [12:0] step_clamp(input logic [12:0] pos, input logic up,
                                               input logic [12:0] lo, input logic [12:0] hi);
        logic [13:0] sum;
        sum = {1'b0, pos} + {1'b0, STP};
        if (up) begin
            step_clamp = (sum >= {1'b0, hi}) ? hi : sum[12:0];
        end else begin
            step_clamp = ({1'b0, pos} <= ({1'b0, lo} + {1'b0, STP})) ? lo : pos - STP;
        end
    endfunction

    function automatic logic [12:0] abs_diff(input logic [12:0] a, input logic [12:0] b);
        abs_diff = (a >= b) ? a - b : b - a;
    endfunction

    // Direction 1 means +; edges override the held direction.
    assign dirx_n = (bx_q <= B_LO) ? 1'b1 : (bx_q >= BX_HI) ? 1'b0 : dirx_q;
    assign diry_n = (by_q <= B_LO) ? 1'b1 : (by_q >= BY_HI) ? 1'b0 : diry_q;

    assign sq_op = (state_q == StSqx) ? dx_q : dy_q;
    assign prod  = {13'b0, sq_op} * {13'b0, sq_op};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bx_d    = bx_q;
        by_d    = by_q;
        ux_d    = ux_q;
        uy_d    = uy_q;
        dirx_d  = dirx_q;
        diry_d  = diry_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        acc_d   = acc_q;
        over_d  = over_q;
        case (state_q)
            StIdle: begin
                if (frame_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = StMoveBall;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StMoveBall: begin
                dirx_d  = dirx_n;
                diry_d  = diry_n;
                bx_d    = step_clamp(bx_q, dirx_n, B_LO, BX_HI);
                by_d    = step_clamp(by_q, diry_n, B_LO, BY_HI);
                state_d = StMoveUser;
            end
            StMoveUser: begin
                if (btn_left ^ btn_right) ux_d = step_clamp(ux_q, btn_right, U_LO, UX_HI);
                if (btn_up ^ btn_down)    uy_d = step_clamp(uy_q, btn_down, U_LO, UY_HI);
                state_d = StDist;
            end
            StDist: begin
                dx_d    = abs_diff(bx_q, ux_q);
                dy_d    = abs_diff(by_q, uy_q);
                state_d = StSqx;
            end
            StSqx: begin
                acc_d   = {1'b0, prod};
                state_d = StSqy;
            end
            StSqy: begin
                acc_d   = acc_q + {1'b0, prod};
                state_d = StCmp;
            end
            StCmp: begin
                if (acc_q <= HIT_LIM) begin
                    over_d  = 1'b1;
                    state_d = StOver;
                end else begin
                    state_d = StIdle;
                end
            end
            StOver: begin
                if (restart) begin
                    bx_d    = PX0;
                    by_d    = PY0;
                    ux_d    = UX0;
                    uy_d    = UY0;
                    dirx_d  = 1'b1;
                    diry_d  = 1'b0;
                    cnt_d   = '0;
                    over_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bx_q    <= PX0;
            by_q    <= PY0;
            ux_q    <= UX0;
            uy_q    <= UY0;
            dirx_q  <= 1'b1;
            diry_q  <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            acc_q   <= '0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            ux_q    <= ux_d;
            uy_q    <= uy_d;
            dirx_q  <= dirx_d;
            diry_q  <= diry_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            acc_q   <= acc_d;
            over_q  <= over_d;
        end
    end

    assign ball_x    = bx_q;
    assign ball_y    = by_q;
    assign user_x    = ux_q;
    assign user_y    = uy_q;
    assign game_over = over_q;
    assign busy      = (state_q != StIdle) && (state_q != StOver);

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Randomized bench for ball_game_ctrl: two differently configured instances driven by the
// same inputs, each compared against a per-frame behavioural model.
module tb_ball_game_ctrl;

    typedef struct {
        int h, v, r, ur, st, div, px, py, ux, uy;
    } cfg_t;

    // Committed (visible) state plus the result of an in-flight update.
    typedef struct {
        int bx, by, ux, uy, dx, dy, over, cnt, timer;
        int pbx, pby, pux, puy, pdx, pdy, pover;
    } mdl_t;

    localparam int NCYC = 20000;

    logic clk = 1'b0;
    logic rst, frame_tick, bl, br, bu, bd, restart;
    logic [12:0] a_bx, a_by, a_ux, a_uy, b_bx, b_by, b_ux, b_uy;
    logic a_go, a_busy, b_go, b_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ball_game_ctrl dut_a (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd), .restart(restart),
        .ball_x(a_bx), .ball_y(a_by), .user_x(a_ux), .user_y(a_uy),
        .game_over(a_go), .busy(a_busy)
    );

    ball_game_ctrl #(
        .H_ACT(640), .V_ACT(480), .RADIUS(30), .U_RADIUS(20), .STEP(2), .FRAME_DIV(3),
        .PX_INIT(608), .PY_INIT(32), .UX_INIT(605), .UY_INIT(440)
    ) dut_b (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(bl), .btn_right(br), .btn_up(bu), .btn_down(bd), .restart(restart),
        .ball_x(b_bx), .ball_y(b_by), .user_x(b_ux), .user_y(b_uy),
        .game_over(b_go), .busy(b_busy)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic mdl_t reset_m(input cfg_t c);
        mdl_t m;
        m.bx = c.px; m.by = c.py; m.ux = c.ux; m.uy = c.uy;
        m.dx = 1; m.dy = -1; m.over = 0; m.cnt = 0; m.timer = 0;
        m.pbx = m.bx; m.pby = m.by; m.pux = m.ux; m.puy = m.uy;
        m.pdx = m.dx; m.pdy = m.dy; m.pover = 0;
        return m;
    endfunction

    // One clock edge of the reference: an accepted tick computes the whole frame update at
    // once; it becomes visible six cycles later, when the busy window closes.
    function automatic mdl_t step_m(input cfg_t c, input mdl_t m_in, input bit r, input bit t,
                                    input bit l, input bit rt, input bit u, input bit d,
                                    input bit rs);
        mdl_t m;
        int mvx, mvy, ddx, ddy;
        m = m_in;
        if (r) return reset_m(c);
        if (m.timer > 0) begin
            if (m.timer == 6) begin
                m.bx = m.pbx; m.by = m.pby; m.ux = m.pux; m.uy = m.puy;
                m.dx = m.pdx; m.dy = m.pdy; m.over = m.pover; m.timer = 0;
            end else begin
                m.timer++;
            end
        end else if (m.over != 0) begin
            if (rs) m = reset_m(c);
        end else if (t) begin
            if (m.cnt == c.div - 1) begin
                m.cnt = 0;
                m.timer = 1;
                m.pdx = m.dx;
                if (m.bx <= c.r) m.pdx = 1;
                else if (m.bx >= c.h - c.r) m.pdx = -1;
                m.pdy = m.dy;
                if (m.by <= c.r) m.pdy = 1;
                else if (m.by >= c.v - c.r) m.pdy = -1;
                m.pbx = clampi(m.bx + m.pdx * c.st, c.r, c.h - c.r);
                m.pby = clampi(m.by + m.pdy * c.st, c.r, c.v - c.r);
                mvx = int'(rt) - int'(l);
                mvy = int'(d) - int'(u);
                m.pux = (mvx != 0) ? clampi(m.ux + mvx * c.st, c.ur, c.h - c.ur) : m.ux;
                m.puy = (mvy != 0) ? clampi(m.uy + mvy * c.st, c.ur, c.v - c.ur) : m.uy;
                ddx = m.pbx - m.pux;
                ddy = m.pby - m.puy;
                m.pover = (ddx * ddx + ddy * ddy <= (c.r + c.ur) * (c.r + c.ur)) ? 1 : 0;
            end else begin
                m.cnt++;
            end
        end
        return m;
    endfunction

    initial begin
        cfg_t ca, cb;
        mdl_t ma, mb;
        ca = '{h: 640, v: 480, r: 30, ur: 30, st: 1, div: 1, px: 200, py: 200, ux: 400, uy: 400};
        cb = '{h: 640, v: 480, r: 30, ur: 20, st: 2, div: 3, px: 608, py: 32, ux: 605, uy: 440};
        rst = 1'b1; frame_tick = 1'b0; restart = 1'b0;
        bl = 1'b0; br = 1'b0; bu = 1'b0; bd = 1'b0;
        repeat (2) @(posedge clk);
        ma = reset_m(ca);
        mb = reset_m(cb);
        for (int i = 0; i < NCYC; i++) begin
            @(negedge clk);
            check_eq("a_busy", int'(a_busy), int'(ma.timer > 0));
            check_eq("a_game_over", int'(a_go), ma.over);
            check_eq("b_busy", int'(b_busy), int'(mb.timer > 0));
            check_eq("b_game_over", int'(b_go), mb.over);
            if (ma.timer == 0) begin
                check_eq("a_ball_x", int'(a_bx), ma.bx);
                check_eq("a_ball_y", int'(a_by), ma.by);
                check_eq("a_user_x", int'(a_ux), ma.ux);
                check_eq("a_user_y", int'(a_uy), ma.uy);
            end
            if (mb.timer == 0) begin
                check_eq("b_ball_x", int'(b_bx), mb.bx);
                check_eq("b_ball_y", int'(b_by), mb.by);
                check_eq("b_user_x", int'(b_ux), mb.ux);
                check_eq("b_user_y", int'(b_uy), mb.uy);
            end
            rst        = ($urandom_range(0, 999) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            restart    = ($urandom_range(0, 15) == 0);
            // Buttons only change while both instances are idle so each update sees one set.
            if (ma.timer == 0 && mb.timer == 0 && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    br = (ma.ux < ma.bx); bl = (ma.ux > ma.bx);
                    bd = (ma.uy < ma.by); bu = (ma.uy > ma.by);
                end else begin
                    {bl, br, bu, bd} = 4'($urandom_range(0, 15));
                end
            end
            @(posedge clk);
            ma = step_m(ca, ma, rst, frame_tick, bl, br, bu, bd, restart);
            mb = step_m(cb, mb, rst, frame_tick, bl, br, bu, bd, restart);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
